// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings for the multicycle MIPS control sequencer
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_REG      = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_SEXT     = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_ADDI  = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // A store only retires once memory accepts the write.
  function automatic logic retires(input state_t s, input logic mem_ready);
    logic r;
    case (s)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: r = 1'b1;
      S_MEMWR:                                     r = mem_ready;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_decode_rom.sv
// rtl/control_decode_rom.sv - combinational state-to-control-vector map
module control_decode_rom
  import multicycle_control_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADDI;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control sequencer with retire/cycle counters
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] cycle_count
);

  state_t state;
  logic   is_store;
  ctrl_t  rom_ctrl;
  ctrl_t  ctrl;

  control_decode_rom u_rom (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (rom_ctrl)
  );

  // Reset overrides the decode so nothing leaks out of an abandoned instruction.
  assign ctrl = reset ? '0 : rom_ctrl;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign state_o     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      is_store      <= 1'b0;
      illegal_op    <= 1'b0;
      instr_retired <= '0;
      cycle_count   <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      if (retires(state, mem_ready))
        instr_retired <= instr_retired + 1'b1;

      case (state)
        S_FETCH:   if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          // The opcode is only trusted here; MEMADR uses the latched lw/sw choice.
          is_store <= (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDI_EX;
            default: begin
              state      <= S_FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  state <= is_store ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_EXEC:    state <= S_RWB;
        S_ADDI_EX: state <= S_ADDI_WB;
        default:   state <= S_FETCH;
      endcase
    end
  end

endmodule
